// File: rtl/circular_buffer_pkg.sv
// Shared types and defaults for the circular buffer controller.
package circular_buffer_pkg;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rd_state_e;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/circular_buffer_read_seq.sv
// Read-side FSM: drains the datapath into a registered output stage.
module circular_buffer_read_seq
    import circular_buffer_pkg::*;
#(
    parameter int ROW_SIZE = 8,
    parameter int PAR_READ = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         buf_empty,
    input  logic [ROW_SIZE*PAR_READ-1:0] buf_dout,
    input  logic                         out_ready,
    output logic                         update_read_pointer,
    output logic                         out_valid,
    output logic [ROW_SIZE*PAR_READ-1:0] out_data
);

    localparam int DW = ROW_SIZE * PAR_READ;

    rd_state_e         state_q, state_d;
    logic [DW-1:0]     data_q, data_d;
    logic              load;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!buf_empty) begin
                    load    = 1'b1;
                    state_d = R_VALID;
                end
            end
            R_VALID: begin
                if (out_ready) begin
                    if (!buf_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = R_IDLE;
                    end
                end
            end
        endcase
        if (load) begin
            data_d = buf_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // The pointer only moves on a real load, and never under reset.
    assign update_read_pointer = load && !rst;
    assign out_valid           = (state_q == R_VALID);
    assign out_data            = data_q;

endmodule

// File: rtl/circular_buffer_controller.sv
// Sequencing controller for circular_buffer_datapath: write handshake,
// read drain stage and wrapping performance counters.
module circular_buffer_controller
    import circular_buffer_pkg::*;
#(
    parameter int ROW_SIZE = 8,
    parameter int PAR_READ = 4,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         buf_full,
    input  logic                         buf_empty,
    input  logic [ROW_SIZE*PAR_READ-1:0] buf_dout,
    output logic                         wen,
    output logic                         update_write_pointer,
    output logic                         update_read_pointer,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROW_SIZE*PAR_READ-1:0] out_data,
    input  logic                         clear_counts,
    output logic [CNT_W-1:0]             wr_count,
    output logic [CNT_W-1:0]             rd_count
);

    logic             wr_fire;
    logic             rd_fire;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    assign in_ready             = !rst && !buf_full;
    assign wr_fire              = in_valid && in_ready;
    assign wen                  = wr_fire;
    assign update_write_pointer = wr_fire;

    circular_buffer_read_seq #(
        .ROW_SIZE (ROW_SIZE),
        .PAR_READ (PAR_READ)
    ) u_read_seq (
        .clk                 (clk),
        .rst                 (rst),
        .buf_empty           (buf_empty),
        .buf_dout            (buf_dout),
        .out_ready           (out_ready),
        .update_read_pointer (update_read_pointer),
        .out_valid           (out_valid),
        .out_data            (out_data)
    );

    assign rd_fire = out_valid && out_ready;

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (clear_counts) begin
            wr_count_d = '0;
            rd_count_d = '0;
        end else begin
            if (wr_fire) wr_count_d = wr_count_q + 1'b1;
            if (rd_fire) rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule
